// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_ctrl slice: FSM state encoding, IR field positions,
// reset pc constant and the jump-condition helper.
// Optional halt feature is enabled by defining CPU_HALT_EN (see cpu_ctrl.sv).
package cpu_pkg;

  // Two-state fetch/execute controller
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

  // Instruction register field positions
  localparam int IR_TYPE   = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int IR_A      = 12;  // alu_y source: 1 = in_m, 0 = A
  localparam int IR_CTL_HI = 11;  // alu_ctl = IR[11:6]
  localparam int IR_CTL_LO = 6;
  localparam int IR_DEST_A = 5;
  localparam int IR_DEST_D = 4;
  localparam int IR_DEST_M = 3;
  localparam int IR_JLT    = 2;
  localparam int IR_JEQ    = 1;
  localparam int IR_JGT    = 0;

  localparam logic [14:0] PC_RST = 15'h0000;

  // Jump decision from the three jump bits {lt,eq,gt} and the ALU flags
  function automatic logic jump_take(input logic [2:0] jmp, input logic zr, input logic ng);
    return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/cpu_pc_reg.sv
// Program counter: 15-bit register with load (jump) and increment; increment wraps 7FFF -> 0000.
// Load has priority over increment; holds when neither is asserted.
// Synchronous active-low reset to PC_RST.
module pc_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [14:0] load_val_i,
  input  logic        inc_i,
  output logic [14:0] pc_o
);

  logic [14:0] pc_q;
  logic [14:0] pc_d;

  // Next pc: jump target, pc+1 (natural 15-bit wrap) or hold
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 15'd1;
    end
  end

  // Register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= PC_RST;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_ctrl.sv
// Hack-style CPU controller: FETCH latches the instruction, EXEC runs it against an external ALU.
// Latency 2 cycles from instr_vld to commit, +1 per mem_rdy=0 cycle on memory-accessing C-instructions.
// Optional halt/halted ports when CPU_HALT_EN is defined (halt freezes the FSM in FETCH).
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
`ifdef CPU_HALT_EN
  input  logic        halt,
  output logic        halted,
`endif
  output logic [14:0] pc,
  input  logic [15:0] instr,
  input  logic        instr_vld,
  output logic [14:0] addr_m,
  input  logic [15:0] in_m,
  output logic [15:0] out_m,
  output logic        write_m,
  input  logic        mem_rdy,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctl,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng
);

  state_e      state_q;
  logic [15:0] ir_q;
  logic [15:0] a_q;
  logic [15:0] d_q;
  logic        write_m_q;

  logic        halt_w;
  logic        is_c;
  logic        mem_acc;
  logic        commit;
  logic        take;

`ifdef CPU_HALT_EN
  assign halt_w = halt;
  assign halted = (state_q == ST_FETCH) & halt;
`else
  assign halt_w = 1'b0;
`endif

  // Decode of the latched instruction; a stalled memory access holds EXEC until mem_rdy
  assign is_c    = ir_q[IR_TYPE];
  assign mem_acc = is_c & (ir_q[IR_A] | ir_q[IR_DEST_M]);
  assign commit  = (state_q == ST_EXEC) & (~mem_acc | mem_rdy);
  assign take    = is_c & jump_take(ir_q[IR_JLT:IR_JGT], alu_zr, alu_ng);

  // Jump target is the pre-commit A, since A updates on the same edge as pc
  pc_reg u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (commit & take),
    .load_val_i (a_q[14:0]),
    .inc_i      (commit & ~take),
    .pc_o       (pc)
  );

  // Fetch/execute FSM with registered write_m; reset overrides any pending commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ir_q      <= 16'h0000;
      a_q       <= 16'h0000;
      d_q       <= 16'h0000;
      write_m_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (instr_vld && !halt_w) begin
            ir_q      <= instr;
            state_q   <= ST_EXEC;
            write_m_q <= instr[IR_TYPE] & instr[IR_DEST_M];
          end
        end
        ST_EXEC: begin
          if (commit) begin
            state_q   <= ST_FETCH;
            write_m_q <= 1'b0;
            if (!is_c) begin
              a_q <= {1'b0, ir_q[14:0]};
            end else begin
              if (ir_q[IR_DEST_A]) a_q <= alu_out;
              if (ir_q[IR_DEST_D]) d_q <= alu_out;
            end
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign addr_m  = a_q[14:0];
  assign out_m   = alu_out;
  assign write_m = write_m_q;
  assign alu_x   = d_q;
  assign alu_y   = ir_q[IR_A] ? in_m : a_q;
  assign alu_ctl = ir_q[IR_CTL_HI:IR_CTL_LO];

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 pc  output  15  instruction fetch address.
REQ-004 instr  input  16  instruction word at pc.
REQ-005 instr_vld  input  1  instr valid this cycle.
REQ-006 addr_m  output  15  data memory address, always equal to register A.
REQ-007 in_m  input  16  data memory read word at addr_m.
REQ-008 out_m  output  16  data memory write word, equal to alu_out.
REQ-009 write_m  output  1  data memory write enable.
REQ-010 mem_rdy  input  1  data memory ready; completes the current read or write.
REQ-011 alu_x, alu_y  output  16 each  ALU operands.
REQ-012 alu_ctl  output  6  ALU controls {zx,nx,zy,ny,f,no}.
REQ-013 alu_out  input  16  ALU result.
REQ-014 alu_zr, alu_ng  input  1 each  ALU zero and negative flags.

Function
REQ-015 The FSM SHALL have two states.
- FETCH: pc is driven; on instr_vld=1, IR<=instr and the FSM goes to EXEC; otherwise it holds.
REQ-016 A-instruction (IR[15]=0) in EXEC:
- A<={1'b0, IR[14:0]}; pc<=pc+1; the FSM goes to FETCH.
- There is no memory access, and mem_rdy is ignored.
REQ-017 C-instruction (IR[15]=1), operand and control fields:
- alu_x=D; alu_y=IR[12] ? in_m : A; alu_ctl=IR[11:6].
- Destination bits: IR[5]=A, IR[4]=D, IR[3]=M.
- Jump bits: IR[2]=lt, IR[1]=eq, IR[0]=gt.
- IR[14:13] are ignored.
REQ-018 write_m SHALL equal IR[3] for the entire C-instruction EXEC state, and SHALL be 0 in every other state.
REQ-019 A C-instruction accesses memory when IR[12]=1 or IR[3]=1.
- While it accesses memory and mem_rdy=0, EXEC holds and every register and output stays stable.
- The instruction commits in the first EXEC cycle with mem_rdy=1, or immediately if it does not access memory.
REQ-020 On commit:
- A<=alu_out if IR[5]=1; D<=alu_out if IR[4]=1.
- take = (lt&alu_ng) | (eq&alu_zr) | (gt&~alu_ng&~alu_zr).
- pc<= take ? A : pc+1; the FSM goes to FETCH.
REQ-021 The jump target, addr_m and alu_y SHALL use A's pre-commit value when the same instruction also writes A.
REQ-022 pc SHALL wrap from 15'h7FFF to 15'h0000 on increment.
REQ-023 Latency: 2 cycles from instr_vld to commit, plus one cycle per mem_rdy=0 cycle on memory-accessing instructions.

Reset
REQ-024 While rst_n=0 at a clock edge, from any state including mid-EXEC, the following SHALL hold next cycle:
- FSM=FETCH; pc=0; A=0; D=0; IR=0; write_m=0.
REQ-025 A pending memory write SHALL be abandoned, and the reset takes priority over mem_rdy in the same cycle.

Configuration
REQ-026 With CPU_HALT_EN defined, the block SHALL add input halt (1 bit) and output halted (1 bit).
- halt is sampled only in FETCH; while halt=1 the FSM stays in FETCH, ignores instr_vld, and drives halted=1.
- halted=0 in every other case.
REQ-027 Without CPU_HALT_EN, both ports SHALL be absent and behaviour SHALL equal halt=0.

Structure
REQ-028 Shared package cpu_pkg SHALL hold:
- the FSM state encoding (FETCH, EXEC);
- IR field positions (type, a, alu_ctl, dest, jump);
- the 15-bit reset pc constant.
REQ-029 The sub-module pc_reg (15-bit register with load, increment and wrap) SHALL be instantiated once; everything else is inline.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset release, instr=16'h0005 with instr_vld=1 -> two cycles later A=5, pc=1, write_m never 1.
- A=5, D=0, instr=16'hEC10 (D=A) -> D=5. Then instr=16'hE308 (M=D) with mem_rdy=0 for 3 cycles -> addr_m=5, out_m=5, write_m=1 held, pc unchanged until the mem_rdy=1 cycle.
- A=5, instr=16'hFC10 (D=M), in_m=16'h1234 -> D=16'h1234 after mem_rdy.
- A=10, D=0, instr=16'hE302 (D;JEQ) -> pc=10. Repeat with D=1 -> pc=old pc+1.
- pc=15'h7FFF executing an A-instruction -> pc=0.
- rst_n=0 in EXEC while write_m=1 and mem_rdy=1 -> next cycle write_m=0, pc=0, FSM=FETCH, and the write is not committed.
